dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single data-memory port between the MIPS core's data interface (requester 0) and a secondary master such as a loader/DMA engine (requester 1). It sits between the requesters and `dmem`: it drives the memory address, write data and write enable, and returns registered read data. It uses round-robin arbitration with an optional bounded lock for back-to-back bursts.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and dmem bus bundle for the two-port data-memory arbiter
//
// Purpose: carries both requesters' request channels, their grant/read-return
// signals and the shared data-memory port as one bundle.
// Ports (signals):
//   req0/req1, we0/we1, lock0/lock1          requester -> arbiter controls
//   addr0/addr1, wdata0/wdata1 [DATA_W]      requester -> arbiter address/data
//   gnt0/gnt1, rvalid0/rvalid1               arbiter -> requester handshake
//   rdata [DATA_W]                           arbiter -> requesters, shared read data
//   mem_addr, mem_write_data [DATA_W]        arbiter -> dmem
//   mem_write_en                             arbiter -> dmem
//   mem_read_data [DATA_W]                   dmem -> arbiter, combinational read
// Modports: slave = arbiter view; master = requesters plus memory view.

interface dmem_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic              lock0;
   logic              lock1;
   logic [DATA_W-1:0] addr0;
   logic [DATA_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1,
      input  mem_read_data,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
      output mem_addr, mem_write_data, mem_write_en
   );

   modport master (
      output req0, req1, we0, we1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1,
      output mem_read_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
      input  mem_addr, mem_write_data, mem_write_en
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with bounded lock for the shared data-memory port
//
// Purpose: shares one dmem port between the core data interface (requester 0)
// and a secondary master (requester 1). Grants are combinational; read data is
// registered and returned one cycle after the read transfer.
// Ports:
//   clk    in   system clock, all state on the rising edge
//   reset  in   synchronous, active-high reset
//   bus    slave modport of dmem_arbiter_if (requesters + dmem port)
// Parameters:
//   DATA_W    data/address width, must match the interface instance
//   MAX_HOLD  max consecutive locked grants while the other side waits (>= 1)

module dmem_arbiter #(
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_R0   = 2'd1,
      OWN_R1   = 2'd2
   } owner_t;

   owner_t              owner_q, owner_d;
   logic                last_q, last_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                rvalid0_q, rvalid0_d;
   logic                rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                win_valid;
   logic                win_id;
   logic                xfer;
   logic                sel_we;
   logic                sel_lock;

   // Winner selection. A lock owner keeps the port while it still requests,
   // unless the other side is waiting and the hold budget is spent; in that
   // case the tie falls through to round-robin, which always favours the
   // waiting side because the owner was the last one granted.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      if (owner_q == OWN_R0 && bus.req0 && (!bus.req1 || hold_q < HOLD_LIMIT)) begin
         win_valid = 1'b1;
         win_id    = 1'b0;
      end else if (owner_q == OWN_R1 && bus.req1 && (!bus.req0 || hold_q < HOLD_LIMIT)) begin
         win_valid = 1'b1;
         win_id    = 1'b1;
      end else if (bus.req0 && !bus.req1) begin
         win_valid = 1'b1;
         win_id    = 1'b0;
      end else if (!bus.req0 && bus.req1) begin
         win_valid = 1'b1;
         win_id    = 1'b1;
      end else if (bus.req0 && bus.req1) begin
         win_valid = 1'b1;
         win_id    = ~last_q;
      end
   end

   // Reset suppresses the transfer itself, so nothing downstream (grant,
   // write strobe, rvalid, state update) can fire in a reset cycle.
   assign xfer     = win_valid & ~reset;
   assign sel_we   = win_id ? bus.we1   : bus.we0;
   assign sel_lock = win_id ? bus.lock1 : bus.lock0;

   assign bus.gnt0 = xfer & ~win_id;
   assign bus.gnt1 = xfer &  win_id;

   // With no winner the mux parks on requester 0, the core, so its address
   // is already on the port when it next asks.
   assign bus.mem_addr       = (win_valid && win_id) ? bus.addr1  : bus.addr0;
   assign bus.mem_write_data = (win_valid && win_id) ? bus.wdata1 : bus.wdata0;
   assign bus.mem_write_en   = xfer & sel_we & ~reset;

   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata   = rdata_q;

   // Next-state: ownership, hold budget, round-robin pointer and read return.
   always_comb begin
      owner_d   = OWN_NONE;
      hold_d    = '0;
      last_d    = last_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rdata_d   = rdata_q;

      if (xfer) begin
         last_d = win_id;
         if (sel_lock) begin
            owner_d = win_id ? OWN_R1 : OWN_R0;
            // Continuing the same owner extends the run; a new owner, or one
            // coming back after a gap, starts a fresh run of one.
            if (owner_q == owner_d) begin
               hold_d = (hold_q >= HOLD_LIMIT) ? HOLD_LIMIT : hold_q + HOLD_W'(1);
            end else begin
               hold_d = HOLD_W'(1);
            end
         end
         if (!sel_we) begin
            rdata_d = bus.mem_read_data;
            if (win_id) begin
               rvalid1_d = 1'b1;
            end else begin
               rvalid0_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q   <= OWN_NONE;
         last_q    <= 1'b1;
         hold_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata_q   <= rdata_d;
      end
   end

   // Structural invariants of the grant logic.
   a_gnt_onehot: assert property (@(posedge clk) !(bus.gnt0 && bus.gnt1));
   a_gnt0_req:   assert property (@(posedge clk) bus.gnt0 |-> bus.req0);
   a_gnt1_req:   assert property (@(posedge clk) bus.gnt1 |-> bus.req1);
   a_no_wr_rst:  assert property (@(posedge clk) reset |-> !bus.mem_write_en);
   a_rvalid_one: assert property (@(posedge clk) !(bus.rvalid0 && bus.rvalid1));
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter

module tb_dmem_arbiter;
   localparam int DATA_W = 32;
   localparam logic [31:0] P10 = 32'hC0DE_0010;
   localparam logic [31:0] P20 = 32'hC0DE_0020;

   logic clk;
   logic reset;

   dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

   dmem_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: unwritten words read back a pattern derived from their
   // byte address; writes are stored XOR-ed with that pattern.
   bit [31:0] mem_store [0:255];

   function automatic logic [31:0] pat(input logic [7:0] idx);
      return 32'hC0DE_0000 | {22'd0, idx, 2'b00};
   endfunction

   assign bus.mem_read_data = mem_store[bus.mem_addr[9:2]] ^ pat(bus.mem_addr[9:2]);

   always @(posedge clk) begin
      if (bus.mem_write_en)
         mem_store[bus.mem_addr[9:2]] <= bus.mem_write_data ^ pat(bus.mem_addr[9:2]);
   end

   int checks = 0;
   int errors = 0;
   int violations = 0;

   always @(negedge clk) begin
      if ((bus.gnt0 && bus.gnt1) || (bus.gnt0 && !bus.req0) || (bus.gnt1 && !bus.req1))
         violations <= violations + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst;
      logic        r0, w0, l0;
      logic [31:0] a0, d0;
      logic        r1, w1, l1;
      logic [31:0] a1, d1;
      logic        eg0, eg1, ewe;
      logic [31:0] eaddr;
      logic        erv0, erv1;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rst,
                      input logic r0, input logic w0, input logic l0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic ewe,
                      input logic [31:0] eaddr,
                      input logic erv0, input logic erv1, input logic [31:0] erd);
      vec_t v;
      v.name = name; v.rst = rst;
      v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.eaddr = eaddr;
      v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst,
                        input logic r0, input logic w0, input logic l0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1);
      reset = rst;
      bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
   endtask

   initial begin
      //   name            rst r0 w0 l0 a0     d0            r1 w1 l1 a1     d1            g0 g1 we addr   rv0 rv1 rdata
      add("rst_hold",      1,  1, 0, 0, 'h10, 0,            1, 0, 0, 'h20, 0,            0, 0, 0, 'h10, 0, 0, 0);
      add("alt_c0",        0,  1, 0, 0, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 0, 0, 0);
      add("alt_c1",        0,  1, 0, 0, 'h10, 0,            1, 0, 0, 'h20, 0,            0, 1, 0, 'h20, 1, 0, P10);
      add("alt_c2",        0,  1, 0, 0, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 0, 1, P20);
      add("alt_c3",        0,  1, 0, 0, 'h10, 0,            1, 0, 0, 'h20, 0,            0, 1, 0, 'h20, 1, 0, P10);
      add("wr1",           0,  0, 0, 0, 0,     0,            1, 1, 0, 'h40, 'hDEADBEEF,   0, 1, 1, 'h40, 0, 1, P20);
      add("rd0_after_wr",  0,  1, 0, 0, 'h40, 0,            0, 0, 0, 0,     0,            1, 0, 0, 'h40, 0, 0, P20);
      add("rd0_data",      0,  0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 0,     1, 0, 'hDEADBEEF);
      add("r1_solo",       0,  0, 0, 0, 0,     0,            1, 0, 0, 'h20, 0,            0, 1, 0, 'h20, 0, 0, 'hDEADBEEF);
      add("lock0_b1",      0,  1, 0, 1, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 0, 1, P20);
      add("lock0_b2",      0,  1, 0, 1, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 1, 0, P10);
      add("lock0_b3",      0,  1, 0, 1, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 1, 0, P10);
      add("lock0_b4",      0,  1, 0, 1, 'h10, 0,            1, 0, 0, 'h20, 0,            1, 0, 0, 'h10, 1, 0, P10);
      add("lock0_yield",   0,  1, 0, 1, 'h10, 0,            1, 0, 0, 'h20, 0,            0, 1, 0, 'h20, 1, 0, P10);
      add("lock1_b1",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_b2",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_b3",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_b4",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_b5",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_b6",      0,  0, 0, 0, 0,     0,            1, 0, 1, 'h20, 0,            0, 1, 0, 'h20, 0, 1, P20);
      add("lock1_then_r0", 0,  1, 0, 0, 'h10, 0,            1, 0, 1, 'h20, 0,            1, 0, 0, 'h10, 0, 1, P20);
      add("rd1_grant",     0,  0, 0, 0, 0,     0,            1, 0, 0, 'h20, 0,            0, 1, 0, 'h20, 1, 0, P10);
      add("rst_after_rd",  1,  1, 1, 0, 'h44, 'h12345678,   1, 0, 0, 'h20, 0,            0, 0, 0, 'h44, 0, 1, P20);
      add("rst_2",         1,  1, 1, 0, 'h44, 'h12345678,   1, 0, 0, 'h20, 0,            0, 0, 0, 'h44, 0, 0, 0);
      add("rel_wr0",       0,  1, 1, 0, 'h44, 'h12345678,   1, 0, 0, 'h20, 0,            1, 0, 1, 'h44, 0, 0, 0);
      add("rd0_back",      0,  1, 0, 0, 'h44, 0,            0, 0, 0, 0,     0,            1, 0, 0, 'h44, 0, 0, 0);
      add("rd0_back_data", 0,  0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 0,     1, 0, 'h12345678);

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
               vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
         @(negedge clk);
         chk({vecs[i].name, ".gnt0"},         32'(bus.gnt0),         32'(vecs[i].eg0));
         chk({vecs[i].name, ".gnt1"},         32'(bus.gnt1),         32'(vecs[i].eg1));
         chk({vecs[i].name, ".mem_write_en"}, 32'(bus.mem_write_en), 32'(vecs[i].ewe));
         chk({vecs[i].name, ".mem_addr"},     bus.mem_addr,          vecs[i].eaddr);
         chk({vecs[i].name, ".rvalid0"},      32'(bus.rvalid0),      32'(vecs[i].erv0));
         chk({vecs[i].name, ".rvalid1"},      32'(bus.rvalid1),      32'(vecs[i].erv1));
         chk({vecs[i].name, ".rdata"},        bus.rdata,             vecs[i].erd);
         @(posedge clk);
         #1;
      end

      // Locked run with the other side waiting: count the consecutive
      // requester-0 grants before the forced yield to requester 1.
      begin
         int  run;
         bit  yielded;
         run     = 0;
         yielded = 1'b0;
         drive(0, 1, 0, 1, 'h10, 0, 1, 0, 0, 'h20, 0);
         for (int c = 0; c < 20 && !yielded; c++) begin
            @(negedge clk);
            if (bus.gnt0)
               run++;
            else if (bus.gnt1 && run > 0)
               yielded = 1'b1;
            @(posedge clk);
            #1;
         end
         chk("hold_run_len", 32'(run),     32'd4);
         chk("hold_yielded", 32'(yielded), 32'd1);
      end

      // A request dropped before it is granted leaves nothing behind.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("idle.gnt0",    32'(bus.gnt0),    32'd0);
      chk("idle.gnt1",    32'(bus.gnt1),    32'd0);
      chk("idle.rvalid1", 32'(bus.rvalid1), 32'd0);

      chk("grant_invariants", 32'(violations), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
